// File: rtl/fetch_ctrl_if.sv
// Fetch-side bundle: instruction-memory handshake, redirect input and decode handoff.
// The master side is the fetch sequencer; the slave side is the memory/core environment.
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_ready;
    logic [1:0]  outst_cnt;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output id_valid, id_pc, id_inst,
        input  id_ready,
        output outst_cnt
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  id_valid, id_pc, id_inst,
        output id_ready,
        input  outst_cnt
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: in-order imem requests under a shared credit of 2,
// a 2-entry fetch queue toward decode, and stale-response dropping after redirects.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master fc_if
);
    localparam logic [2:0] CREDITS = 3'(MAX_OUTST);

    logic [31:0] fpc_q, fpc_d;
    logic [1:0]  outst_q, outst_d;
    logic [1:0]  drop_q, drop_d;
    logic        infl_head_q, infl_head_d;
    logic [31:0] infl_pc_q [2];
    logic        q_head_q, q_head_d;
    logic [1:0]  q_cnt_q, q_cnt_d;
    logic [31:0] q_pc_q [2];
    logic [31:0] q_inst_q [2];

    logic can_issue, issue, resp, push, pop, id_valid;
    logic infl_wr_idx, q_wr_idx;

    // Credit counts both in-flight requests and queued entries, so a push can never hit a full queue.
    assign can_issue   = ({1'b0, outst_q} + {1'b0, q_cnt_q}) < CREDITS;
    assign fc_if.imem_req  = !rst && !fc_if.redirect_valid && can_issue;
    assign fc_if.imem_addr = fpc_q;
    assign issue       = fc_if.imem_req && fc_if.imem_gnt;

    // A response with nothing outstanding can only be a leftover from before reset.
    assign resp        = fc_if.imem_rvalid && (outst_q != 2'd0);
    assign push        = resp && !fc_if.redirect_valid && (drop_q == 2'd0);
    assign id_valid    = (q_cnt_q != 2'd0);
    assign pop         = id_valid && fc_if.id_ready && !fc_if.redirect_valid;
    assign infl_wr_idx = infl_head_q ^ outst_q[0];
    assign q_wr_idx    = q_head_q ^ q_cnt_q[0];

    assign fc_if.id_valid  = id_valid;
    assign fc_if.id_pc     = id_valid ? q_pc_q[q_head_q]   : 32'h0;
    assign fc_if.id_inst   = id_valid ? q_inst_q[q_head_q] : 32'h0;
    assign fc_if.outst_cnt = outst_q;

    always_comb begin
        fpc_d       = fpc_q;
        outst_d     = outst_q;
        drop_d      = drop_q;
        infl_head_d = infl_head_q;
        q_head_d    = q_head_q;
        q_cnt_d     = q_cnt_q;

        if (issue) begin
            fpc_d = fpc_q + 32'd4;
        end

        case ({issue, resp})
            2'b10:   outst_d = outst_q + 2'd1;
            2'b01:   outst_d = outst_q - 2'd1;
            default: outst_d = outst_q;
        endcase

        if (resp) begin
            infl_head_d = ~infl_head_q;
        end

        if (fc_if.redirect_valid) begin
            // Everything still in flight after this edge belongs to the old stream.
            fpc_d    = fc_if.redirect_pc;
            drop_d   = outst_q - {1'b0, resp};
            q_head_d = 1'b0;
            q_cnt_d  = 2'd0;
        end else begin
            if (resp && (drop_q != 2'd0)) begin
                drop_d = drop_q - 2'd1;
            end
            if (pop) begin
                q_head_d = ~q_head_q;
            end
            case ({push, pop})
                2'b10:   q_cnt_d = q_cnt_q + 2'd1;
                2'b01:   q_cnt_d = q_cnt_q - 2'd1;
                default: q_cnt_d = q_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q       <= RESET_PC;
            outst_q     <= 2'd0;
            drop_q      <= 2'd0;
            infl_head_q <= 1'b0;
            q_head_q    <= 1'b0;
            q_cnt_q     <= 2'd0;
        end else begin
            fpc_q       <= fpc_d;
            outst_q     <= outst_d;
            drop_q      <= drop_d;
            infl_head_q <= infl_head_d;
            q_head_q    <= q_head_d;
            q_cnt_q     <= q_cnt_d;
        end
    end

    // Payload storage needs no reset; validity lives entirely in the counters above.
    always_ff @(posedge clk) begin
        if (issue) begin
            infl_pc_q[infl_wr_idx] <= fpc_q;
        end
        if (push) begin
            q_pc_q[q_wr_idx]   <= infl_pc_q[infl_head_q];
            q_inst_q[q_wr_idx] <= fc_if.imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: queue-based reference model plus an in-order memory responder,
// checked every cycle, with directed scenarios pinning literal expectations.
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .MAX_OUTST(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .fc_if (bus)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

    mreq_t       mq[$];
    int          last_due = 0;
    logic [31:0] m_fpc;
    logic [31:0] m_infl[$];
    ent_t        m_dq[$];
    int          m_drop;
    logic [31:0] gnt_log[$];
    logic [31:0] pop_log[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int gnt_mode = 1;
    int lat_min = 1;
    int lat_max = 1;
    int stall = 0;
    bit started = 1'b0;
    int first_gnt_cyc = -1;
    int first_idv_cyc = -1;
    logic [31:0] first_inst;
    int pops = 0;
    bit have_last = 1'b0;
    logic [31:0] last_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F69;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Memory responder, per-cycle compare and model update.
    always @(negedge clk) begin : cmp
        logic        e_req;
        logic [31:0] rp;
        ent_t        dummy;
        bit          g, resp;
        int          old_n, lat;

        cyc++;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(mq[0].addr);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'hDEAD_BEEF;
        end
        bus.imem_gnt = (gnt_mode == 0) ? 1'b1 : (gnt_mode == 1) ? 1'b0 : (stall == 0);
        #2;

        e_req = !rst && !bus.redirect_valid && (m_infl.size() + m_dq.size() < 2);
        if (started) begin
            chk("imem_req",  32'(bus.imem_req), 32'(e_req));
            chk("imem_addr", bus.imem_addr, m_fpc);
            chk("outst_cnt", 32'(bus.outst_cnt), 32'(m_infl.size()));
            chk("id_valid",  32'(bus.id_valid), 32'(m_dq.size() != 0));
            chk("id_pc",     bus.id_pc,   (m_dq.size() != 0) ? m_dq[0].pc   : 32'h0);
            chk("id_inst",   bus.id_inst, (m_dq.size() != 0) ? m_dq[0].inst : 32'h0);
            chk("inv_outst_le2", 32'(bus.outst_cnt <= 2'd2), 32'd1);
            chk("inv_credit",    32'(int'(bus.outst_cnt) + m_dq.size() <= 2), 32'd1);
            chk("inv_drop",      32'(m_drop <= int'(bus.outst_cnt)), 32'd1);
            if (bus.id_valid && first_idv_cyc < 0) begin
                first_idv_cyc = cyc;
                first_inst    = bus.id_inst;
            end
        end

        g = bus.imem_req && bus.imem_gnt;
        if (g) begin
            if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
            gnt_log.push_back(bus.imem_addr);
            lat = $urandom_range(lat_max, lat_min);
            last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            mq.push_back('{addr: bus.imem_addr, due: last_due});
        end
        if (bus.imem_rvalid) mq.delete(0);
        if (stall > 0) stall--;
        else if (g && gnt_mode == 2 && $urandom_range(0, 4) == 0) stall = 3;

        if (!started || rst || bus.redirect_valid) begin
            have_last = 1'b0;
        end else if (bus.id_valid && bus.id_ready) begin
            pops++;
            pop_log.push_back(bus.id_pc);
            if (have_last) chk("pc_seq", bus.id_pc, last_pc + 32'd4);
            last_pc   = bus.id_pc;
            have_last = 1'b1;
        end

        if (rst) begin
            m_fpc = 32'h0000_0000;
            m_infl.delete();
            m_dq.delete();
            m_drop  = 0;
            started = 1'b1;
        end else begin
            old_n = m_infl.size();
            resp  = bus.imem_rvalid && old_n > 0;
            rp    = 32'h0;
            if (resp) rp = m_infl.pop_front();
            if (bus.redirect_valid) begin
                m_drop = old_n - (resp ? 1 : 0);
                m_dq.delete();
                m_fpc = bus.redirect_pc;
            end else begin
                if (m_dq.size() > 0 && bus.id_ready) dummy = m_dq.pop_front();
                if (resp) begin
                    if (m_drop > 0) m_drop--;
                    else m_dq.push_back('{pc: rp, inst: mem_word(rp)});
                end
            end
            if (e_req && bus.imem_gnt) begin
                m_infl.push_back(m_fpc);
                m_fpc = m_fpc + 32'd4;
            end
        end
    end

    task automatic quiesce();
        gnt_mode = 1;
        bus.id_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 60 && mq.size() != 0; i++) tick(1);
        chk("quiesce_drain", 32'(mq.size()), 32'd0);
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.id_ready       = 1'b0;
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 32'h0;
        tick(3);

        // Streaming: gnt always, 1-cycle latency, decode always ready.
        rst = 1'b0;
        bus.id_ready = 1'b1;
        gnt_mode = 0;
        gnt_log.delete();
        first_gnt_cyc = -1;
        first_idv_cyc = -1;
        chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
        chk("rst_outst", 32'(bus.outst_cnt), 32'd0);
        tick(8);
        chk("s1_addr0", gnt_log[0], 32'h0);
        chk("s1_addr1", gnt_log[1], 32'h4);
        chk("s1_addr2", gnt_log[2], 32'h8);
        chk("s1_first_latency", 32'(first_idv_cyc - first_gnt_cyc), 32'd2);
        chk("s1_first_inst", first_inst, 32'hA5C3_0F69);
        pops = 0;
        tick(12);
        chk("s1_throughput", 32'(pops >= 6), 32'd1);

        // Backpressure: decode stalls for 6 cycles.
        quiesce();
        bus.id_ready = 1'b0;
        gnt_mode = 0;
        lat_min = 1;
        lat_max = 1;
        tick(4);
        chk("s2_req_blocked", 32'(bus.imem_req), 32'd0);
        chk("s2_hold_pc", bus.id_pc, 32'h0);
        chk("s2_hold_inst", bus.id_inst, 32'hA5C3_0F69);
        tick(1);
        chk("s2_req_blocked2", 32'(bus.imem_req), 32'd0);
        chk("s2_hold_pc2", bus.id_pc, 32'h0);
        tick(1);
        bus.id_ready = 1'b1;
        pop_log.delete();
        gnt_log.delete();
        tick(6);
        chk("s2_pop_count", 32'(pop_log.size() >= 2), 32'd1);
        chk("s2_pop0", pop_log[0], 32'h0);
        chk("s2_pop1", pop_log[1], 32'h4);
        chk("s2_resume_addr", gnt_log[0], 32'h8);

        // Redirect with 0x8 and 0xC outstanding.
        quiesce();
        gnt_mode = 0;
        lat_min = 3;
        lat_max = 3;
        tick(7);
        chk("s3_outst_before", 32'(bus.outst_cnt), 32'd2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        pop_log.delete();
        tick(1);
        bus.redirect_valid = 1'b0;
        tick(20);
        chk("s3_pop_count", 32'(pop_log.size() >= 2), 32'd1);
        chk("s3_pop0", pop_log[0], 32'h100);
        chk("s3_pop1", pop_log[1], 32'h104);

        // Redirect on a response cycle, then a second redirect while one drop is pending.
        quiesce();
        gnt_mode = 0;
        lat_min = 3;
        lat_max = 3;
        tick(8);
        chk("s4_outst_before", 32'(bus.outst_cnt), 32'd2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h180;
        pop_log.delete();
        gnt_log.delete();
        tick(1);
        bus.redirect_pc = 32'h200;
        tick(1);
        bus.redirect_valid = 1'b0;
        tick(20);
        chk("s4_first_gnt", gnt_log[0], 32'h200);
        chk("s4_pop_count", 32'(pop_log.size() >= 1), 32'd1);
        chk("s4_pop0", pop_log[0], 32'h200);
        gnt_mode = 1;
        tick(10);
        chk("s4_idle_outst", 32'(bus.outst_cnt), 32'd0);

        // Address wrap, then randomised latency, stalls, backpressure and redirects.
        quiesce();
        gnt_mode = 2;
        lat_min = 1;
        lat_max = 4;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFF8;
        gnt_log.delete();
        tick(1);
        bus.redirect_valid = 1'b0;
        tick(30);
        chk("s5_wrap0", gnt_log[0], 32'hFFFF_FFF8);
        chk("s5_wrap1", gnt_log[1], 32'hFFFF_FFFC);
        chk("s5_wrap2", gnt_log[2], 32'h0000_0000);
        for (int i = 0; i < 10000; i++) begin
            bus.id_ready       = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 59) == 0);
            bus.redirect_pc    = {14'h0, 16'($urandom), 2'b00};
            tick(1);
        end
        bus.redirect_valid = 1'b0;

        // Reset with a full queue, then with two requests in flight.
        quiesce();
        bus.id_ready = 1'b0;
        gnt_mode = 0;
        lat_min = 1;
        lat_max = 1;
        tick(4);
        chk("s6_qfull", 32'(bus.id_valid), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        lat_min = 6;
        lat_max = 6;
        chk("s6a_id_valid", 32'(bus.id_valid), 32'd0);
        chk("s6a_outst", 32'(bus.outst_cnt), 32'd0);
        chk("s6a_addr", bus.imem_addr, 32'h0);
        tick(2);
        chk("s6b_outst_before", 32'(bus.outst_cnt), 32'd2);
        gnt_mode = 1;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("s6b_id_valid", 32'(bus.id_valid), 32'd0);
        chk("s6b_outst", 32'(bus.outst_cnt), 32'd0);
        chk("s6b_addr", bus.imem_addr, 32'h0);
        tick(8);
        chk("s6b_stale_drained", 32'(mq.size()), 32'd0);
        chk("s6b_no_valid", 32'(bus.id_valid), 32'd0);
        chk("s6b_outst_after", 32'(bus.outst_cnt), 32'd0);
        gnt_mode = 0;
        gnt_log.delete();
        tick(5);
        chk("s6b_restart_addr", gnt_log[0], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the pipelined core variant.
- Owns the fetch PC and issues in-order requests to instruction memory over a req/gnt/rvalid handshake, with up to 2 requests outstanding.
- Buffers returned instructions with their PCs in a 2-entry queue that feeds decode over a valid/ready interface.
- On branch/jump redirect it flushes the queue and discards in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- MAX_OUTST, 2, maximum outstanding requests plus queued entries (credit limit); fixed at 2 for this revision.

Ports:
- clk  input  1  system clock, all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address; equals the fetch PC register.
- imem_gnt  input  1  request accepted this cycle (when imem_req=1).
- imem_rvalid  input  1  response data valid; responses return in request order, at least 1 cycle after gnt.
- imem_rdata  input  32  instruction word.
- redirect_valid  input  1  branch/jump taken; fetch restarts at redirect_pc.
- redirect_pc  input  32  redirect target, word aligned.
- id_valid  output  1  queue head valid.
- id_pc  output  32  PC of queue head.
- id_inst  output  32  instruction of queue head.
- id_ready  input  1  decode accepts head this cycle.
- outst_cnt  output  2  requests granted but not yet answered (debug/perf).

Behaviour:
- Reset (rst=1 at edge):
  - fpc=RESET_PC, outst=0, drop=0, queue count=0.
  - imem_req=0 while rst=1.
  - id_valid=0, id_pc=0, id_inst=0.
- Credit:
  - can_issue = (outst + qcount) < MAX_OUTST, using current registered values with no same-cycle pop bypass.
  - imem_req = !rst && !redirect_valid && can_issue (combinational).
  - imem_addr = fpc.
- Request:
  - On imem_req && imem_gnt: fpc <= fpc+4 (32-bit wrap at 0xFFFF_FFFC -> 0); outst++.
  - The issued address is pushed into a 2-entry in-flight PC FIFO.
  - imem_req may drop without gnt only on redirect; the memory tolerates withdrawal.
- Response:
  - On imem_rvalid: outst-- and the in-flight PC FIFO is popped.
  - If drop>0: the response is discarded and drop--.
  - Otherwise {pc, rdata} is pushed to the queue; visible on id_* the next cycle (1-cycle registered latency).
  - Gnt and rvalid in the same cycle: outst is unchanged.
- Decode handoff:
  - id_valid = (qcount != 0).
  - On id_valid && id_ready the head is popped.
  - Push and pop in the same cycle are both performed, in FIFO order.
  - The credit rule guarantees no push when full.
  - id_pc/id_inst hold stable while id_valid=1 and id_ready=0.
- Redirect (highest priority below rst):
  - fpc <= redirect_pc; queue flushed (qcount=0, id_valid=0 next cycle).
  - A same-cycle pop is ignored.
  - No request is issued that cycle.
  - drop <= outst - (imem_rvalid ? 1 : 0), which covers stale responses already in flight.
  - The in-flight PC FIFO keeps its entries for the stale responses; they are popped as those responses arrive.
  - A response arriving in the redirect cycle is discarded regardless of drop.
  - A redirect during drop>0 recomputes drop by the same formula; because drop ≤ outst this stays correct.
- New-stream requests:
  - New-stream requests may issue while drops are pending, subject to credit.
  - Ordering guarantees the stale responses are consumed first.
- Reset mid-operation: all counters and the queue clear immediately; late rvalid after reset is ignored (outst=0, no push, no underflow). The memory is reset together with this block.
- Invariants (assert in bench):
  - outst ≤ 2; qcount ≤ 2; drop ≤ outst; outst + qcount ≤ 2.
  - No rvalid while outst=0 except after reset.

Test Plan:
- Reset then gnt always 1, rvalid 1 cycle after gnt, id_ready=1:
  - imem_addr sequence 0x0, 0x4, 0x8…
  - id_pc first valid 2 cycles after the first gnt, with id_inst matching the rdata for that address.
  - Sustained throughput of 1 instruction per 2 cycles.
- Backpressure: id_ready=0 for 6 cycles:
  - After 2 instructions are queued, imem_req stays 0.
  - id_pc/id_inst are stable.
  - Releasing id_ready drains in order (0x0, 0x4) and resumes requests at 0x8.
- Redirect with 2 outstanding (addr 0x8, 0xC granted), redirect_pc=0x100:
  - Both stale responses are dropped; id_valid stays 0 until the 0x100 instruction arrives.
  - id_pc=0x100, then 0x104.
- Redirect coinciding with rvalid, plus a second redirect to 0x200 while drop=1:
  - No stale instruction reaches decode; the first id_pc=0x200; outst returns to 0 when the pipe idles.
- Variable latency (gnt stalls 3 cycles, rvalid delays 1–4 cycles, random id_ready):
  - imem_addr holds while gnt=0.
  - Decoded PC stream is strictly +4 sequential.
  - All invariants hold over 10k cycles.
- Assert rst for 1 cycle with 2 outstanding and a full queue:
  - Next cycle id_valid=0, outst_cnt=0, imem_addr=RESET_PC.
  - Subsequent stale rvalids produce no id_valid.
